// File: rtl/div_seq_if.sv
// Operand/result bundle between the E stage and the iterative divider.
interface div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall_div;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_div, ready, hi, lo
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_div, ready, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// One-bit-per-cycle restoring divider (DIV/DIVU) that stalls F/D/E while busy.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor finishes in one cycle.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     resetn,
  div_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             ready_r;

  logic             accept;
  logic             last;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quo_n;

  assign accept = (state == IDLE) && bus.start && !bus.annul;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign a_neg  = bus.signed_div && bus.a[WIDTH-1];
  assign b_neg  = bus.signed_div && bus.b[WIDTH-1];

  // Restoring step: dividend bits shift out of quo into rem.
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_n   = shifted;
    quo_n   = {quo[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, dvs}) begin
      rem_n    = shifted - {1'b0, dvs};
      quo_n[0] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = BUSY;
`ifdef DIV_ZERO_SHORTCUT_EN
          if (bus.b == '0) state_n = DONE;
`endif
        end
      end
      BUSY:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.annul) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            rem   <= '0;
            cnt   <= '0;
            quo   <= a_neg ? -bus.a : bus.a;
            dvs   <= b_neg ? -bus.b : bus.b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (bus.b == '0) begin
              hi_r <= bus.a;
              lo_r <= a_neg ? WIDTH'(1) : '1;
            end
`endif
          end
        end
        BUSY: begin
          if (!bus.annul) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            // Results land on the final step so they are valid throughout DONE.
            if (last) begin
              lo_r <= neg_q ? -quo_n : quo_n;
              hi_r <= neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by resetn so every output reads 0 while reset is asserted.
  assign bus.stall_div = resetn && !bus.annul &&
                         (((state == IDLE) && bus.start) || (state == BUSY));
  assign bus.ready     = ready_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq with hand-computed quotients and remainders.
module tb_div_seq;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge in IDLE; drives cycle 0 and follows through DONE.
  task automatic do_div(input string tag, input logic sd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                        input logic [W-1:0] exp_hi, input int exp_lat);
    int   cyc;
    logic stall_ok;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = a;
    bus.b          = b;
    #1;
    check({tag, "_stall_c0"}, W'(bus.stall_div), W'(1));
    cyc      = 0;
    stall_ok = 1'b1;
    while (!bus.ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
      #1;
      if (!bus.ready && !bus.stall_div) stall_ok = 1'b0;
    end
    check({tag, "_latency"}, W'(cyc), W'(exp_lat));
    check({tag, "_stall_run"}, W'(stall_ok), W'(1));
    check({tag, "_stall_done"}, W'(bus.stall_div), W'(0));
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_hi"}, bus.hi, exp_hi);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({tag, "_ready_pulse"}, W'(bus.ready), W'(0));
    check({tag, "_no_reaccept"}, W'(bus.stall_div), W'(0));
  endtask

  initial begin
    int zlat;
`ifdef DIV_ZERO_SHORTCUT_EN
    zlat = 1;
`else
    zlat = 33;
`endif
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.annul      = 1'b0;
    #2;
    check("rst_ready", W'(bus.ready), W'(0));
    check("rst_stall", W'(bus.stall_div), W'(0));
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    do_div("divu_100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // Annul mid-operation: accept at cycle 0, flush at cycle 10.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd1000;
    bus.b          = 32'd10;
    for (int i = 0; i < 10; i++) @(negedge clk);
    bus.annul = 1'b1;
    #1;
    check("annul_stall_c10", W'(bus.stall_div), W'(0));
    @(negedge clk);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    #1;
    check("annul_idle_c11", W'(bus.stall_div), W'(0));
    check("annul_no_ready", W'(bus.ready), W'(0));
    check("annul_hi_kept", bus.hi, 32'd2);
    check("annul_lo_kept", bus.lo, 32'd14);
    @(negedge clk);
    do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // start with annul in IDLE must not be accepted.
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    #1;
    check("annul_idle_stall", W'(bus.stall_div), W'(0));
    @(negedge clk);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    #1;
    check("annul_idle_no_acc", W'(bus.stall_div), W'(0));
    @(negedge clk);

    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, zlat);
    do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, zlat);

    // Reset mid-operation with start still high.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd77;
    bus.b          = 32'd4;
    for (int i = 0; i < 20; i++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_stall", W'(bus.stall_div), W'(0));
    check("mid_rst_ready", W'(bus.ready), W'(0));
    check("mid_rst_hi", bus.hi, '0);
    check("mid_rst_lo", bus.lo, '0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_div("divu_1_1", 1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divide sequencer for the MIPS execute stage. It accepts DIV/DIVU operands from E, runs a one-bit-per-cycle restoring division, and returns quotient (LO) and remainder (HI). While it runs it drives the divider stall that freezes F/D/E through the hazard unit. M and W continue, so in-flight HI/LO and GPR writes still drain and are forwarded normally.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. The iteration count equals `WIDTH`.

Ports:
- `clk`, input, 1: clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: E-stage instruction is DIV/DIVU; held high while the instruction sits in E.
- `signed_div`, input, 1: 1 = DIV, 0 = DIVU. Sampled with `start`.
- `a`, input, WIDTH: dividend (rs). Sampled on acceptance.
- `b`, input, WIDTH: divisor (rt). Sampled on acceptance.
- `annul`, input, 1: E-stage flush (exception/ERET). Cancels any operation.
- `stall_div`, output, 1: drives the hazard unit's `stall_divE`.
- `ready`, output, 1: one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`, output, WIDTH: remainder.
- `lo`, output, WIDTH: quotient.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset puts the FSM in IDLE and clears the counter, `hi`, `lo`, `ready` and `stall_div` to 0.
- **IDLE:**
  - `start & ~annul` means acceptance. The block latches |a|, |b| (absolute values only when `signed_div`), the sign of a, the sign of a XOR sign of b, and `signed_div`.
  - It then clears the partial remainder and the counter, and moves to BUSY.
  - Otherwise it stays in IDLE.
- **BUSY:**
  - Each cycle performs one restoring step: `{rem,quo} <<= 1`; if rem ≥ divisor, then rem -= divisor and quo[0] = 1. The counter increments.
  - After WIDTH steps, the next state is DONE.
- **DONE:**
  - `lo` = quo, negated if signed and the signs differ.
  - `hi` = rem, negated if signed and a < 0.
  - `ready` = 1 for this cycle only. The next state is IDLE unconditionally.
  - `start` still high in DONE belongs to the same instruction, which leaves E at the end of this cycle. It is not re-accepted.
- **Stall rule:** `stall_div` = ~annul & ((IDLE & start) | BUSY). It is combinational and low in DONE.
- **Annul:**
  - Annul in any state forces IDLE on the next edge. No `ready` pulse follows, and `hi`/`lo` are unchanged.
  - `start` and `annul` together in IDLE means no acceptance.
- **Registers and arithmetic:**
  - `hi`/`lo` are registered and hold their value until the next DONE.
  - All arithmetic is WIDTH-bit with wrap-around; the remainder register is WIDTH+1 bits for the compare/subtract.
  - For signed 0x80000000 / 0xFFFFFFFF, the result is lo = 0x80000000 and hi = 0, from the natural wrap.
- **Divide by zero** produces defined values, identical with or without the config macro:
  - Unsigned: lo = all-ones, hi = a.
  - Signed: lo = (a < 0) ? 1 : all-ones, hi = a.
- **Reset mid-operation** asynchronously returns the block to IDLE, with all outputs at 0.

## Timing
- Cycle 0 is acceptance (IDLE, `stall_div` = 1).
- Cycles 1..WIDTH are BUSY (`stall_div` = 1).
- Cycle WIDTH+1 is DONE (`ready` = 1, `stall_div` = 0, `hi`/`lo` valid).
- This gives WIDTH+1 = 33 stall cycles. The E instruction advances to M at the end of cycle WIDTH+1.
- The earliest next acceptance is cycle WIDTH+2, since back-to-back divides pass through IDLE.

## Configuration
- **`DIV_ZERO_SHORTCUT_EN` defined:**
  - On acceptance with b == 0, the FSM goes IDLE → DONE directly.
  - `hi`/`lo` are loaded with the divide-by-zero values above, and `ready` is high in cycle 1.
  - Total stall is 1 cycle.
- **Undefined:** a zero divisor runs the full WIDTH iterations. The restoring algorithm yields the same values, with `ready` in cycle WIDTH+1.

## Test plan
- **Unsigned divide:** DIVU a = 100, b = 7 → `stall_div` high cycles 0..32; `ready` pulse at cycle 33 with lo = 14, hi = 2.
- **Signed, mixed signs:** DIV a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- **Signed overflow:** DIV a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Annul mid-operation:** accept at cycle 0, `annul` at cycle 10 → `stall_div` low in cycle 10 and IDLE at cycle 11. No `ready`; `hi`/`lo` retain the prior result. A new DIVU 9/3 at cycle 12 gives lo = 3, hi = 0 at cycle 45.
- **Divide by zero:**
  - DIVU a = 5, b = 0 → lo = 0xFFFFFFFF, hi = 5.
  - DIV a = −5, b = 0 → lo = 1, hi = 0xFFFFFFFB.
  - Without the macro, `ready` arrives at cycle 33; with `DIV_ZERO_SHORTCUT_EN`, at cycle 1.
- **Reset mid-operation:** drop `resetn` at cycle 20 → `stall_div`, `ready`, `hi`, `lo` all 0 immediately. After release, DIVU 1/1 gives lo = 1, hi = 0 after 33 cycles.
